// File: rtl/keypad_scan_cntr.sv
// rtl/keypad_scan_cntr.sv - 4x4 active-low keypad scanner with press/release debounce
module keypad_scan_cntr #(
  parameter int SCAN_DIV     = 100_000,
  parameter int DEBOUNCE_CNT = 10
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_value,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_FULL      = DB_W'(DEBOUNCE_CNT);
  localparam logic [DB_W-1:0]  DB_LAST_OPEN = DB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;

  logic [3:0]       r_row_m;
  logic [3:0]       r_row_s;
  logic [3:0]       r_col;
  logic [3:0]       r_cap_row;
  logic [3:0]       r_cap_col;
  logic [3:0]       r_key_value;
  logic             r_key_valid;
  logic             r_key_held;
  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DB_W-1:0]  r_db_cnt;

  logic             w_tick;
  logic             w_row_valid;
  logic [1:0]       w_row_idx;
  logic [1:0]       w_cap_row_idx;
  logic [1:0]       w_col_idx;
  logic [3:0]       w_col_next;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_row_m <= 4'b1111;
      r_row_s <= 4'b1111;
    end else begin
      r_row_m <= row;
      r_row_s <= r_row_m;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_col_next = {r_col[2:0], r_col[3]};

  // Multi-zero patterns (two keys on the driven column) are treated as no key.
  always_comb begin
    w_row_valid = 1'b1;
    w_row_idx   = 2'd0;
    case (r_row_s)
      4'b1110: w_row_idx = 2'd0;
      4'b1101: w_row_idx = 2'd1;
      4'b1011: w_row_idx = 2'd2;
      4'b0111: w_row_idx = 2'd3;
      default: w_row_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_cap_row_idx = 2'd0;
    case (r_cap_row)
      4'b1101: w_cap_row_idx = 2'd1;
      4'b1011: w_cap_row_idx = 2'd2;
      4'b0111: w_cap_row_idx = 2'd3;
      default: w_cap_row_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_col_idx = 2'd0;
    case (r_cap_col)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      r_state     <= ST_SCAN;
      r_col       <= 4'b1110;
      r_cap_row   <= 4'b1111;
      r_cap_col   <= 4'b1110;
      r_db_cnt    <= '0;
      r_key_value <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          ST_SCAN: begin
            if (w_row_valid) begin
              r_cap_row <= r_row_s;
              r_cap_col <= r_col;
              r_db_cnt  <= DB_W'(1);
              r_state   <= ST_DEBOUNCE;
            end else begin
              r_col <= w_col_next;
            end
          end
          // The capture tick counts as the first stable sample.
          ST_DEBOUNCE: begin
            if (r_row_s == r_cap_row) begin
              if (r_db_cnt == DB_FULL) begin
                r_key_value <= {w_cap_row_idx, w_col_idx};
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
                r_db_cnt    <= '0;
                r_state     <= ST_PRESSED;
              end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
              end
            end else begin
              r_db_cnt <= '0;
              r_state  <= ST_SCAN;
            end
          end
          ST_PRESSED: begin
            if (r_row_s == 4'b1111) begin
              if (r_db_cnt == DB_LAST_OPEN) begin
                r_key_held <= 1'b0;
                r_db_cnt   <= '0;
                r_col      <= w_col_next;
                r_state    <= ST_SCAN;
              end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
              end
            end else begin
              r_db_cnt <= '0;
            end
          end
          default: begin
            r_db_cnt <= '0;
            r_state  <= ST_SCAN;
          end
        endcase
      end
    end
  end

  assign col       = r_col;
  assign key_value = r_key_value;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule
